// File: rtl/cu_write_arbiter_control.sv
`default_nettype none
// ============================================================================
//  Module   : cu_write_arbiter_control
//  Purpose  : Round-robin arbiter that merges NUM_REQ write requesters onto a
//             single registered write command/data path, with back-pressure
//             from the downstream command buffer almost-full flag.
//  Options  : CU_WRITE_ARB_GRANT_COUNT_EN - when defined, per-requester
//             32-bit grant counters drive grant_count_out; otherwise those
//             outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================

package cu_write_arbiter_pkg;

  // One write command; valid doubles as the request line.
  typedef struct packed {
    logic        valid;
    logic [1:0]  opcode;
    logic [31:0] address;
    logic [7:0]  length;
  } CommandBufferLine;

  // One half of a write data beat.
  typedef logic [63:0] ReadWriteDataLine;

  // Downstream buffer status; the arbiter only looks at alfull.
  typedef struct packed {
    logic full;
    logic alfull;
    logic empty;
  } BufferStatus;

endpackage

module cu_write_arbiter_control
  import cu_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = 2
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 enabled_in,
  input  CommandBufferLine     write_command_in [NUM_REQ],
  input  ReadWriteDataLine     write_data_0_in  [NUM_REQ],
  input  ReadWriteDataLine     write_data_1_in  [NUM_REQ],
  input  BufferStatus          write_command_buffer_status,
  output logic [NUM_REQ-1:0]   grant_out,
  output CommandBufferLine     write_command_out,
  output ReadWriteDataLine     write_data_0_out,
  output ReadWriteDataLine     write_data_1_out,
  output logic [31:0]          write_grant_total_out,
  output logic [31:0]          grant_count_out  [NUM_REQ]
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARBITRATE = 2'd1,
    S_STALL     = 2'd2
  } state_t;

  localparam logic [REQ_BITS-1:0] c_last_reset = REQ_BITS'(NUM_REQ - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_enabled;
  logic [REQ_BITS-1:0]   r_last_grant;
  logic                  w_sel_found;
  logic [REQ_BITS-1:0]   w_sel_idx;
  logic                  w_alfull;
  logic                  w_fire;
  CommandBufferLine      r_cmd;
  ReadWriteDataLine      r_data_0;
  ReadWriteDataLine      r_data_1;
  logic [31:0]           r_grant_total;
  logic                  w_unused_status;

  assign w_alfull        = write_command_buffer_status.alfull;
  assign w_unused_status = ^{write_command_buffer_status.full,
                             write_command_buffer_status.empty};

  // Enable is sampled one cycle before it influences the FSM or grants.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_enabled <= 1'b0;
    end else begin
      r_enabled <= enabled_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a low registered enable always forces IDLE.
  always_comb begin
    w_state_next = r_state;
    if (!r_enabled) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      w_state_next = S_ARBITRATE;
        S_ARBITRATE: w_state_next = w_alfull ? S_STALL : S_ARBITRATE;
        S_STALL:     w_state_next = w_alfull ? S_STALL : S_ARBITRATE;
        default:     w_state_next = S_IDLE;
      endcase
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      automatic int probe = int'(r_last_grant) + k;
      if (probe >= NUM_REQ) begin
        probe = probe - NUM_REQ;
      end
      if (!w_sel_found && write_command_in[REQ_BITS'(probe)].valid) begin
        w_sel_found = 1'b1;
        w_sel_idx   = REQ_BITS'(probe);
      end
    end
  end

  // A grant needs ARBITRATE, no almost-full this cycle and a still-high
  // registered enable, so grants stop the cycle after enable drops rather
  // than one cycle later when the FSM reaches IDLE.
  assign w_fire = (r_state == S_ARBITRATE) && r_enabled && !w_alfull && w_sel_found;

  // One-hot grant, combinational in the selection cycle.
  always_comb begin
    grant_out = '0;
    if (w_fire) begin
      grant_out[w_sel_idx] = 1'b1;
    end
  end

  // Remember the winner only when a grant actually goes out.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_last_grant <= c_last_reset;
    end else if (w_fire) begin
      r_last_grant <= w_sel_idx;
    end
  end

  // Register the granted beat; any non-grant cycle produces an all-zero beat.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_cmd    <= '0;
      r_data_0 <= '0;
      r_data_1 <= '0;
    end else if (w_fire) begin
      r_cmd    <= write_command_in[w_sel_idx];
      r_data_0 <= write_data_0_in[w_sel_idx];
      r_data_1 <= write_data_1_in[w_sel_idx];
    end else begin
      r_cmd    <= '0;
      r_data_0 <= '0;
      r_data_1 <= '0;
    end
  end

  // Total grants since reset, wrapping at 2^32.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_grant_total <= '0;
    end else if (w_fire) begin
      r_grant_total <= r_grant_total + 32'd1;
    end
  end

  assign write_command_out     = r_cmd;
  assign write_data_0_out      = r_data_0;
  assign write_data_1_out      = r_data_1;
  assign write_grant_total_out = r_grant_total;

`ifdef CU_WRITE_ARB_GRANT_COUNT_EN
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
      logic [31:0] r_count;

      // Per-requester grant count, wrapping at 2^32.
      always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
          r_count <= '0;
        end else if (w_fire && (w_sel_idx == REQ_BITS'(gi))) begin
          r_count <= r_count + 32'd1;
        end
      end

      assign grant_count_out[gi] = r_count;
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt_tie
      assign grant_count_out[gi] = '0;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
